// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment display scan controller: register map,
// CTRL bit positions, scan FSM encoding and segment/anode helpers.
package display_scan_ctrl_pkg;

    localparam logic [3:0] DISP_DATA     = 4'd0;
    localparam logic [3:0] DISP_CTRL     = 4'd4;
    localparam logic [3:0] DISP_PRESCALE = 4'd8;
    localparam logic [3:0] DISP_RAW      = 4'd12;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RAW    = 1;
    localparam int CTRL_DP_LSB = 4;

    localparam logic [7:0]  SEG_OFF     = 8'hFF;
    localparam logic [11:0] DISPLAY_OFF = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } scan_state_e;

    // Active-low anode vector with only digit idx driven.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        anode_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern {dp,g,f,e,d,c,b,a};
// the decimal point is always left off.
module hex_to_seg7
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Glyph table.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// iobus slave holding the display registers and the scan FSM that strobes
// one anode at a time with a blank gap between digits.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd1000,
    parameter int          BLANK_CYCLES = 2
)
(
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic [11:0] g_display
);

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    logic [15:0] data_q, data_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] raw_q, raw_d;
    logic        ready_q, ready_d;
    logic [31:0] dout_q, dout_d;

    scan_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  seg_q, seg_d;
    logic [11:0] disp_q, disp_d;

    logic        req_s, wr_s, rd_only_s;
    logic [31:0] rdata_s;
    logic [3:0]  nibble_s;
    logic [7:0]  hex_seg_s, raw_byte_s, load_pat_s;
    logic [3:0]  dp_mask_s;
    logic [15:0] on_last_s;
    logic        unused_s;

    assign unused_s  = ^addr[1:0];
    assign req_s     = cs & (read | write);
    assign wr_s      = cs & write;
    assign rd_only_s = cs & read & ~write;

    // Register readback mux.
    always_comb begin
        rdata_s = 32'd0;
        case (addr[3:2])
            DISP_DATA[3:2]:     rdata_s = {16'd0, data_q};
            DISP_CTRL[3:2]:     rdata_s = {24'd0, ctrl_q};
            DISP_PRESCALE[3:2]: rdata_s = {16'd0, prescale_q};
            DISP_RAW[3:2]:      rdata_s = raw_q;
            default:            rdata_s = 32'd0;
        endcase
    end

    // Register writes and the one-cycle ready/data_out response.
    always_comb begin
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        raw_d      = raw_q;
        ready_d    = req_s;
        dout_d     = dout_q;
        if (wr_s) begin
            dout_d = data_in;
            case (addr[3:2])
                DISP_DATA[3:2]:     data_d     = data_in[15:0];
                DISP_CTRL[3:2]:     ctrl_d     = {data_in[7:4], 2'b00, data_in[1:0]};
                DISP_PRESCALE[3:2]: prescale_d = data_in[15:0];
                DISP_RAW[3:2]:      raw_d      = data_in;
                default:            data_d     = data_q;
            endcase
        end else if (rd_only_s) begin
            dout_d = rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    assign nibble_s   = data_q[{idx_q, 2'b00} +: 4];
    assign raw_byte_s = raw_q[{idx_q, 3'b000} +: 8];
    assign dp_mask_s  = ctrl_q[CTRL_DP_LSB +: 4];
    assign on_last_s  = (prescale_q == 16'd0) ? 16'd0 : (prescale_q - 16'd1);

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_s),
        .seg    (hex_seg_s)
    );

    // Pattern captured at LOAD, so mid-digit register writes never glitch the glass.
    always_comb begin
        load_pat_s = ctrl_q[CTRL_RAW] ? raw_byte_s : hex_seg_s;
        if (dp_mask_s[idx_q]) begin
            load_pat_s = load_pat_s & 8'h7F;
        end else begin
            load_pat_s = load_pat_s;
        end
    end

    // Scan FSM next state; the display is registered from the next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        if (!ctrl_q[CTRL_EN]) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_LOAD;
                ST_LOAD: begin
                    seg_d   = load_pat_s;
                    cnt_d   = on_last_s;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == 16'd0) begin
                        cnt_d   = BLANK_LAST;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == 16'd0) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                end
            endcase
        end
        disp_d = (state_d == ST_SHOW) ? {anode_sel(idx_d), seg_d} : DISPLAY_OFF;
    end

    // State registers with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            data_q     <= 16'd0;
            ctrl_q     <= 8'd0;
            prescale_q <= PRESCALE_RST;
            raw_q      <= 32'd0;
            ready_q    <= 1'b0;
            dout_q     <= 32'd0;
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 16'd0;
            seg_q      <= SEG_OFF;
            disp_q     <= DISPLAY_OFF;
        end else begin
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            raw_q      <= raw_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_d;
            disp_q     <= disp_d;
        end
    end

    assign ready     = ready_q;
    assign data_out  = dout_q;
    assign g_display = disp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a
// digit-period reference model.
module tb_display_scan_ctrl;

    localparam int B = 2;

    logic        g_clk = 1'b0;
    logic        rst_r = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] data_out;
    logic        ready;
    logic [11:0] g_display;

    int checks = 0;
    int failures = 0;

    display_scan_ctrl #(.PRESCALE_RST(16'd1000), .BLANK_CYCLES(B)) dut (
        .g_clk(g_clk), .g_rst(rst_r), .cs(cs), .addr(addr), .read(rd), .write(wr),
        .data_in(din), .data_out(data_out), .ready(ready), .g_display(g_display)
    );

    always #5 g_clk = ~g_clk;

    // Reference model state
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [15:0] m_data;
    logic [7:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [31:0] m_raw;
    logic        m_ready;
    logic [31:0] m_dout;
    logic [11:0] m_disp;
    bit          m_run;
    int          m_off, m_len, m_idx;
    logic [7:0]  m_pat;

    function automatic logic [7:0] digit_pattern(input int n);
        logic [7:0] p;
        p = m_ctrl[1] ? m_raw[8*n +: 8] : hex_tab[m_data[4*n +: 4]];
        if (m_ctrl[4+n]) p = p & 8'h7F;
        return p;
    endfunction

    function automatic logic [31:0] readback(input logic [3:0] a);
        case (a[3:2])
            2'd0: return {16'd0, m_data};
            2'd1: return {24'd0, m_ctrl};
            2'd2: return {16'd0, m_pre};
            default: return m_raw;
        endcase
    endfunction

    task automatic model_edge(input logic c, input logic r, input logic w,
                              input logic [3:0] a, input logic [31:0] d);
        logic [3:0] an;
        if (rst_r) begin
            m_data = 16'd0; m_ctrl = 8'd0; m_pre = 16'd1000; m_raw = 32'd0;
            m_ready = 1'b0; m_dout = 32'd0; m_disp = 12'hFFF;
            m_run = 0; m_off = 0; m_idx = 0; m_len = 1; m_pat = 8'hFF;
            return;
        end
        m_disp = 12'hFFF;
        if (!m_ctrl[0]) begin
            m_run = 0; m_idx = 0;
        end else if (!m_run) begin
            m_run = 1; m_off = 0;
        end else begin
            m_off = m_off + 1;
            if (m_off == 1) begin
                m_len = (m_pre == 16'd0) ? 1 : int'(m_pre);
                m_pat = digit_pattern(m_idx);
            end
            if (m_off <= m_len) begin
                an = 4'hF;
                an[m_idx] = 1'b0;
                m_disp = {an, m_pat};
            end else if (m_off == m_len + B + 1) begin
                m_idx = (m_idx + 1) % 4;
                m_off = 0;
            end
        end
        m_ready = c & (r | w);
        if (c & w) begin
            m_dout = d;
            case (a[3:2])
                2'd0: m_data = d[15:0];
                2'd1: m_ctrl = {d[7:4], 2'b00, d[1:0]};
                2'd2: m_pre  = d[15:0];
                default: m_raw = d;
            endcase
        end else if (c & r) begin
            m_dout = readback(a);
        end
    endtask

    task automatic tick(input logic c, input logic r, input logic w,
                        input logic [3:0] a, input logic [31:0] d);
        cs = c; rd = r; wr = w; addr = a; din = d;
        @(posedge g_clk);
        model_edge(c, r, w, a, d);
        #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, 1'b1, a, d);
        idle();
    endtask

    task automatic do_reset();
        rst_r = 1'b1;
        idle();
        rst_r = 1'b0;
    endtask

    task automatic test_reset();
        rst_r = 1'b1;
        idle(); idle();
        checks++;
        if (g_display !== 12'hFFF) begin failures++; $display("FAIL reset_disp got=%h exp=fff", g_display); end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++;
        if (data_out !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", data_out); end
        rst_r = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 4'h8, 32'd0);
        checks++;
        if (ready !== 1'b1 || data_out !== 32'd1000) begin
            failures++; $display("FAIL reset_prescale_read ready=%b dout=%0d exp ready=1 dout=1000", ready, data_out);
        end
        idle();
        checks++;
        if (ready !== 1'b0 || data_out !== 32'd1000) begin
            failures++; $display("FAIL ready_one_cycle ready=%b dout=%0d exp ready=0 dout=1000", ready, data_out);
        end
    endtask

    task automatic test_scan_hex();
        int first, second, cyc;
        bit prev;
        do_reset();
        bus_write(4'h0, 32'h1234);
        bus_write(4'h8, 32'd3);
        bus_write(4'h4, 32'h1);
        first = -1; second = -1; prev = 0;
        for (cyc = 0; cyc < 70; cyc++) begin
            idle();
            checks++;
            if (g_display !== m_disp) begin failures++; $display("FAIL hex_scan cyc=%0d got=%h exp=%h", cyc, g_display, m_disp); end
            if (g_display == 12'hE99 && !prev) begin
                if (first < 0) first = cyc; else if (second < 0) second = cyc;
            end
            prev = (g_display == 12'hE99);
        end
        checks++;
        if (second - first != 24) begin failures++; $display("FAIL frame_len got=%0d exp=24", second - first); end
    endtask

    task automatic test_raw_mode();
        bit saw0;
        do_reset();
        bus_write(4'h8, 32'd3);
        bus_write(4'hC, 32'h00FF_80C0);
        bus_write(4'h4, 32'h13);
        saw0 = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            idle();
            checks++;
            if (g_display !== m_disp) begin failures++; $display("FAIL raw_scan cyc=%0d got=%h exp=%h", cyc, g_display, m_disp); end
            if (g_display[11:8] == 4'hE) begin
                saw0 = 1;
                checks++;
                if (g_display[7:0] !== 8'h40) begin failures++; $display("FAIL raw_dp0 got=%h exp=40", g_display[7:0]); end
            end
        end
        checks++;
        if (!saw0) begin failures++; $display("FAIL raw_digit0_seen got=0 exp=1"); end
    endtask

    task automatic test_glitch_free();
        int budget;
        bit saw1;
        do_reset();
        bus_write(4'h0, 32'h1234);
        bus_write(4'h8, 32'd4);
        bus_write(4'h4, 32'h1);
        budget = 0;
        while (g_display !== 12'hE99 && budget < 40) begin idle(); budget++; end
        checks++;
        if (budget >= 40) begin failures++; $display("FAIL glitch_wait timeout got=%h exp=e99", g_display); end
        tick(1'b1, 1'b0, 1'b1, 4'h0, 32'hFFFF);
        saw1 = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            checks++;
            if (g_display !== m_disp) begin failures++; $display("FAIL glitch_scan cyc=%0d got=%h exp=%h", cyc, g_display, m_disp); end
            if (g_display[11:8] == 4'hE) begin
                checks++;
                if (g_display[7:0] !== 8'h99) begin failures++; $display("FAIL glitch_digit0 got=%h exp=99", g_display[7:0]); end
            end
            if (g_display[11:8] == 4'hD) begin
                saw1 = 1;
                checks++;
                if (g_display[7:0] !== 8'h8E) begin failures++; $display("FAIL glitch_digit1 got=%h exp=8e", g_display[7:0]); end
            end
            idle();
        end
        checks++;
        if (!saw1) begin failures++; $display("FAIL glitch_digit1_seen got=0 exp=1"); end
    endtask

    task automatic test_prescale0_enable();
        int budget, shows;
        do_reset();
        bus_write(4'h0, 32'hC0DE);
        bus_write(4'h8, 32'd0);
        bus_write(4'h4, 32'h1);
        shows = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            idle();
            checks++;
            if (g_display !== m_disp) begin failures++; $display("FAIL presc0 cyc=%0d got=%h exp=%h", cyc, g_display, m_disp); end
            if (g_display[11:8] != 4'hF) shows++;
        end
        checks++;
        if (shows != 4) begin failures++; $display("FAIL presc0_on_cycles got=%0d exp=4", shows); end
        bus_write(4'h8, 32'd6);
        budget = 0;
        while (g_display[11:8] == 4'hF && budget < 40) begin idle(); budget++; end
        idle();
        checks++;
        if (budget >= 40) begin failures++; $display("FAIL en_wait timeout got=%h", g_display); end
        tick(1'b1, 1'b0, 1'b1, 4'h4, 32'h0);
        idle();
        checks++;
        if (g_display !== 12'hFFF) begin failures++; $display("FAIL en_clear got=%h exp=fff", g_display); end
        bus_write(4'h4, 32'h1);
        budget = 0;
        while (g_display == 12'hFFF && budget < 20) begin idle(); budget++; end
        checks++;
        if (g_display[11:8] !== 4'hE || budget >= 20) begin
            failures++; $display("FAIL reenable_digit0 got=%h exp_anode=e", g_display);
        end
    endtask

    task automatic test_read_write_collide();
        do_reset();
        tick(1'b1, 1'b1, 1'b1, 4'h0, 32'hABCD);
        checks++;
        if (ready !== 1'b1 || data_out !== 32'hABCD) begin
            failures++; $display("FAIL rw_collide ready=%b dout=%h exp ready=1 dout=abcd", ready, data_out);
        end
        idle();
        tick(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
        checks++;
        if (data_out !== 32'h0000ABCD) begin failures++; $display("FAIL rw_readback got=%h exp=abcd", data_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        do_reset();
        bus_write(4'hC, $urandom);
        for (int i = 0; i < 6; i++) begin
            a = 4'($urandom_range(0, 3) * 4);
            tick(1'b1, 1'b1, 1'b0, a, 32'd0);
            checks++;
            if (ready !== 1'b1 || data_out !== m_dout) begin
                failures++; $display("FAIL b2b_ready i=%0d ready=%b dout=%h exp=%h", i, ready, data_out, m_dout);
            end
            idle();
            checks++;
            if (ready !== 1'b0) begin failures++; $display("FAIL b2b_gap i=%0d ready=%b exp=0", i, ready); end
        end
        tick(1'b1, 1'b1, 1'b0, 4'h8, 32'd0);
        tick(1'b1, 1'b1, 1'b0, 4'hC, 32'd0);
        checks++;
        if (ready !== 1'b1 || data_out !== m_raw) begin
            failures++; $display("FAIL ready_cycle_accept ready=%b dout=%h exp=%h", ready, data_out, m_raw);
        end
        idle();
    endtask

    task automatic test_random();
        logic [3:0]  a;
        logic [31:0] d;
        logic        r, w;
        do_reset();
        bus_write(4'h8, 32'd2);
        bus_write(4'h4, 32'h1);
        for (int cyc = 0; cyc < 500; cyc++) begin
            if ($urandom_range(0, 9) < 3) begin
                a = 4'($urandom_range(0, 3) * 4);
                w = 1'($urandom_range(0, 1));
                r = w ? 1'($urandom_range(0, 1)) : 1'b1;
                d = $urandom;
                if (a == 4'h8) d = 32'($urandom_range(0, 4));
                if (a == 4'h4) d[0] = ($urandom_range(0, 4) != 0);
                tick(1'b1, r, w, a, d);
            end else begin
                idle();
            end
            checks++;
            if (g_display !== m_disp || ready !== m_ready || (m_ready && data_out !== m_dout)) begin
                failures++;
                $display("FAIL random cyc=%0d disp=%h/%h ready=%b/%b dout=%h/%h",
                         cyc, g_display, m_disp, ready, m_ready, data_out, m_dout);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bus_write(4'h4, 32'h1);
        for (int i = 0; i < 7; i++) idle();
        rst_r = 1'b1;
        idle();
        rst_r = 1'b0;
        checks++;
        if (g_display !== 12'hFFF || ready !== 1'b0 || data_out !== 32'd0) begin
            failures++; $display("FAIL mid_reset disp=%h ready=%b dout=%h exp fff/0/0", g_display, ready, data_out);
        end
        tick(1'b1, 1'b1, 1'b0, 4'h4, 32'd0);
        checks++;
        if (data_out !== 32'd0) begin failures++; $display("FAIL mid_reset_ctrl got=%h exp=0", data_out); end
        idle(); idle();
        checks++;
        if (g_display !== 12'hFFF) begin failures++; $display("FAIL mid_reset_idle got=%h exp=fff", g_display); end
    endtask

    initial begin
        test_reset();
        test_scan_hex();
        test_raw_mode();
        test_glitch_free();
        test_prescale0_enable();
        test_read_write_collide();
        test_back_to_back();
        test_random();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
